// File: rtl/writeback_stage.sv
// Writeback stage: picks the ALU result or D-cache load data and issues one register-file write.
// Optional macro WB_HIZ_IDLE_EN drives writeData to all-z whenever regWrite is low.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      reqValid,
  output logic                      reqReady,
  input  logic                      reqRegWrite,
  input  logic                      reqMemToReg,
  input  logic [REG_ADDR_WIDTH-1:0] reqDestReg,
  input  logic [DATA_WIDTH-1:0]     reqAluResult,
  input  logic [DATA_WIDTH-1:0]     memReadData,
  input  logic                      memDataValid,
  output logic                      regWrite,
  output logic [REG_ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      busy,
  output logic                      memTimeoutErr
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [REG_ADDR_WIDTH-1:0] XZR = REG_ADDR_WIDTH'(31);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  // An ALU result enters WRITE with regWrite low and strobes on the following edge;
  // load data strobes on the edge that samples it. WRITE always covers the strobe cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dest_q        <= '0;
      alu_q         <= '0;
      wdata_q       <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      reqReady      <= 1'b1;
      busy          <= 1'b0;
      memTimeoutErr <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            dest_q <= reqDestReg;
            alu_q  <= reqAluResult;
            cnt    <= '0;
            if (reqRegWrite && (reqDestReg != XZR)) begin
              state    <= reqMemToReg ? WAIT_MEM : WRITE;
              reqReady <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (memDataValid) begin
            state         <= WRITE;
            regWrite      <= 1'b1;
            writeRegister <= dest_q;
            wdata_q       <= memReadData;
          end else if (cnt == CNT_LAST) begin
            // Load abandoned: flag it and retire without a write.
            state         <= IDLE;
            memTimeoutErr <= 1'b1;
            reqReady      <= 1'b1;
            busy          <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (!regWrite) begin
            regWrite      <= 1'b1;
            writeRegister <= dest_q;
            wdata_q       <= alu_q;
          end else begin
            state    <= IDLE;
            reqReady <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_HIZ_IDLE_EN
  // Float the data bus outside write cycles so the register file's z-guard ignores it.
  assign writeData = regWrite ? wdata_q : {DATA_WIDTH{1'bz}};
`else
  assign writeData = wdata_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic checked every cycle
// against a latency-based transaction model.
module tb_writeback_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqRegWrite = 1'b0;
  logic          reqMemToReg = 1'b0;
  logic [AW-1:0] reqDestReg = '0;
  logic [DW-1:0] reqAluResult = '0;
  logic [DW-1:0] memReadData = '0;
  logic          memDataValid = 1'b0;
  logic          regWrite;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic          busy;
  logic          memTimeoutErr;

  int errors = 0;
  int checks = 0;

  writeback_stage #(
    .DATA_WIDTH(DW),
    .REG_ADDR_WIDTH(AW),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqRegWrite(reqRegWrite),
    .reqMemToReg(reqMemToReg),
    .reqDestReg(reqDestReg),
    .reqAluResult(reqAluResult),
    .memReadData(memReadData),
    .memDataValid(memDataValid),
    .regWrite(regWrite),
    .writeRegister(writeRegister),
    .writeData(writeData),
    .busy(busy),
    .memTimeoutErr(memTimeoutErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a job is the accepted request; age counts edges since acceptance.
  bit            cmp_en = 1'b0;
  bit            m_job, m_load, m_wrote;
  int unsigned   m_age, m_wr_age;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_alu;
  bit            m_ready = 1'b1;
  bit            m_rw, m_err;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;

  function automatic logic [DW-1:0] exp_data_out();
`ifdef WB_HIZ_IDLE_EN
    return m_rw ? m_wdata : {DW{1'bz}};
`else
    return m_wdata;
`endif
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_job = 1'b0; m_ready = 1'b1; m_rw = 1'b0;
      m_wreg = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      m_rw = 1'b0;
      if (m_job) begin
        m_age++;
        if (m_wrote) begin
          if (m_age == m_wr_age + 1) begin m_job = 1'b0; m_ready = 1'b1; end
        end else if (!m_load) begin
          if (m_age == 1) begin
            m_rw = 1'b1; m_wreg = m_dest; m_wdata = m_alu; m_wrote = 1'b1; m_wr_age = m_age;
          end
        end else if (memDataValid) begin
          m_rw = 1'b1; m_wreg = m_dest; m_wdata = memReadData; m_wrote = 1'b1; m_wr_age = m_age;
        end else if (m_age == TMO) begin
          m_err = 1'b1; m_job = 1'b0; m_ready = 1'b1;
        end
      end else if (reqValid && reqRegWrite && (reqDestReg != AW'(31))) begin
        m_job = 1'b1; m_load = reqMemToReg; m_age = 0; m_wrote = 1'b0;
        m_dest = reqDestReg; m_alu = reqAluResult; m_ready = 1'b0;
      end
    end
    cmp_en = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("reqReady", 32'(reqReady), 32'(m_ready));
      chk("busy", 32'(busy), 32'(!m_ready));
      chk("regWrite", 32'(regWrite), 32'(m_rw));
      chk("writeRegister", 32'(writeRegister), 32'(m_wreg));
      chk("writeData", writeData, exp_data_out());
      chk("memTimeoutErr", 32'(memTimeoutErr), 32'(m_err));
    end
  end

  function automatic logic [DW-1:0] idle_data(input logic [DW-1:0] held);
`ifdef WB_HIZ_IDLE_EN
    return {DW{1'bz}};
`else
    return held;
`endif
  endfunction

  task automatic clear_req();
    reqValid = 1'b0; reqRegWrite = 1'b0; reqMemToReg = 1'b0;
  endtask

  task automatic drive_req(input logic rw, input logic m2r, input logic [AW-1:0] d, input logic [DW-1:0] a);
    reqValid = 1'b1; reqRegWrite = rw; reqMemToReg = m2r; reqDestReg = d; reqAluResult = a;
  endtask

  initial begin
    int pct;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(reqReady), 32'd1);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeRegister", 32'(writeRegister), 32'd0);
    chk("rst_writeData", writeData, idle_data(32'h0));
    chk("rst_err", 32'(memTimeoutErr), 32'd0);
    reset = 1'b0;

    // ALU write to r5
    drive_req(1'b1, 1'b0, AW'(5), 32'h0000_00A5);
    @(negedge clock); clear_req();
    chk("alu_prep_rw", 32'(regWrite), 32'd0);
    chk("alu_prep_ready", 32'(reqReady), 32'd0);
    @(negedge clock);
    chk("alu_rw", 32'(regWrite), 32'd1);
    chk("alu_wreg", 32'(writeRegister), 32'd5);
    chk("alu_wdata", writeData, 32'h0000_00A5);
    chk("alu_model_wdata", m_wdata, 32'h0000_00A5);
    chk("alu_ready_low", 32'(reqReady), 32'd0);
    @(negedge clock);
    chk("alu_after_rw", 32'(regWrite), 32'd0);
    chk("alu_after_ready", 32'(reqReady), 32'd1);
    chk("alu_hold_wdata", writeData, idle_data(32'h0000_00A5));

    // Load to r9, data three cycles after acceptance
    drive_req(1'b1, 1'b1, AW'(9), 32'h1111_1111);
    @(negedge clock); clear_req();
    for (int i = 0; i < 2; i++) begin
      chk("ld_busy", 32'(busy), 32'd1);
      chk("ld_wait_rw", 32'(regWrite), 32'd0);
      @(negedge clock);
    end
    chk("ld_busy", 32'(busy), 32'd1);
    memDataValid = 1'b1; memReadData = 32'hDEAD_BEEF;
    @(negedge clock); memDataValid = 1'b0;
    chk("ld_rw", 32'(regWrite), 32'd1);
    chk("ld_wreg", 32'(writeRegister), 32'd9);
    chk("ld_wdata", writeData, 32'hDEAD_BEEF);
    chk("ld_model_wreg", 32'(m_wreg), 32'd9);
    @(negedge clock);
    chk("ld_after_rw", 32'(regWrite), 32'd0);

    // XZR and no-destination requests are dropped
    drive_req(1'b1, 1'b0, AW'(31), 32'h5555_5555);
    chk("xzr_ready_pre", 32'(reqReady), 32'd1);
    @(negedge clock);
    chk("xzr_ready", 32'(reqReady), 32'd1);
    chk("xzr_rw", 32'(regWrite), 32'd0);
    drive_req(1'b0, 1'b0, AW'(3), 32'h6666_6666);
    @(negedge clock); clear_req();
    chk("nowr_ready", 32'(reqReady), 32'd1);
    chk("nowr_rw", 32'(regWrite), 32'd0);
    @(negedge clock);
    chk("nowr_rw2", 32'(regWrite), 32'd0);

    // Timeout: load with no data
    drive_req(1'b1, 1'b1, AW'(7), 32'h0);
    @(negedge clock); clear_req();
    repeat (TMO - 1) @(negedge clock);
    chk("tmo_not_yet", 32'(memTimeoutErr), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("tmo_err", 32'(memTimeoutErr), 32'd1);
    chk("tmo_model_err", 32'(m_err), 32'd1);
    chk("tmo_ready", 32'(reqReady), 32'd1);
    chk("tmo_rw", 32'(regWrite), 32'd0);
    drive_req(1'b1, 1'b0, AW'(2), 32'h0000_1234);
    @(negedge clock); clear_req();
    @(negedge clock);
    chk("tmo_alu_rw", 32'(regWrite), 32'd1);
    chk("tmo_alu_wreg", 32'(writeRegister), 32'd2);
    chk("tmo_err_sticky", 32'(memTimeoutErr), 32'd1);
    @(negedge clock);

    // Reset during the second wait cycle discards the load
    drive_req(1'b1, 1'b1, AW'(4), 32'h0);
    @(negedge clock); clear_req();
    @(negedge clock);
    reset = 1'b1; memDataValid = 1'b1; memReadData = 32'hCAFE_F00D;
    @(negedge clock);
    chk("mrst_rw", 32'(regWrite), 32'd0);
    chk("mrst_ready", 32'(reqReady), 32'd1);
    chk("mrst_wreg", 32'(writeRegister), 32'd0);
    chk("mrst_wdata", writeData, idle_data(32'h0));
    chk("mrst_err", 32'(memTimeoutErr), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_no_write", 32'(regWrite), 32'd0);
    chk("mrst_ready2", 32'(reqReady), 32'd1);
    memDataValid = 1'b0;

    // Randomized traffic with varying load-data density
    pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(2, 0))
          0: pct = 50;
          1: pct = 12;
          default: pct = 3;
        endcase
      end
      reset        = ($urandom_range(599, 0) == 0);
      reqValid     = ($urandom_range(99, 0) < 60);
      reqRegWrite  = ($urandom_range(99, 0) < 85);
      reqMemToReg  = $urandom_range(1, 0) == 1;
      reqDestReg   = ($urandom_range(7, 0) == 0) ? AW'(31) : AW'($urandom_range(31, 0));
      reqAluResult = $urandom;
      memReadData  = $urandom;
      memDataValid = ($urandom_range(99, 0) < pct);
      @(negedge clock);
    end
    reset = 1'b0; clear_req(); memDataValid = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
